// File: rtl/l3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l3_pkg
// Brief    : Shared types and constants for the L3 grid initiator side.
// Revision : 1.0 - initial release
// ============================================================================
package l3_pkg;

    localparam int L3_WORD_W       = 32;
    localparam int L3_GRID_LATENCY = 3;
    localparam int L3_TAG_W        = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } l3_state_e;

    typedef struct packed {
        logic [L3_WORD_W-1:0] data;
        logic [L3_TAG_W-1:0]  tag;
    } l3_resp_t;

endpackage
`default_nettype wire

// File: rtl/l3_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : l3_resp_fifo
// Brief    : Synchronous FIFO with push/pop/full/empty/count; pops when empty
//            and pushes when full are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module l3_resp_fifo #(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full     = (r_count == c_CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/l3_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : l3_bus_master
// Brief    : Drives request words onto the L3 grid bus and queues the sampled
//            cache output, with a wrapping tag, in a response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module l3_bus_master
    import l3_pkg::*;
#(
    parameter int                   LATENCY    = L3_GRID_LATENCY,
    parameter int                   FIFO_DEPTH = 4,
    parameter int                   TAG_W      = L3_TAG_W,
    parameter logic [L3_WORD_W-1:0] IDLE_WORD  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [L3_WORD_W-1:0] req_data,
    output logic [L3_WORD_W-1:0] bus_out,
    input  logic [L3_WORD_W-1:0] cache_in,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [L3_WORD_W-1:0] resp_data,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 busy
);

    localparam int c_CNT_W   = $clog2(LATENCY + 1);
    localparam int c_ENTRY_W = L3_WORD_W + TAG_W;
    localparam int c_FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    l3_state_e            r_state;
    l3_state_e            w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [TAG_W-1:0]     r_tag;
    logic [TAG_W-1:0]     w_tag_nxt;
    logic [TAG_W-1:0]     r_cur_tag;
    logic [TAG_W-1:0]     w_cur_tag_nxt;
    logic [L3_WORD_W-1:0] r_bus;
    logic [L3_WORD_W-1:0] w_bus_nxt;
    logic                 w_capture;
    logic                 w_req_ready;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_FCNT_W-1:0]  w_fifo_count;
    logic [c_ENTRY_W-1:0] w_head;

    // Ready depends only on registered state, never on req_valid.
    assign w_req_ready = (r_state == ST_IDLE) && (w_fifo_count < c_FCNT_W'(FIFO_DEPTH));
    assign req_ready   = w_req_ready;
    assign busy        = (r_state == ST_WAIT);
    assign bus_out     = r_bus;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tag_nxt     = r_tag;
        w_cur_tag_nxt = r_cur_tag;
        w_bus_nxt     = r_bus;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && w_req_ready) begin
                    w_bus_nxt     = req_data;
                    w_cnt_nxt     = c_CNT_W'(LATENCY);
                    w_cur_tag_nxt = r_tag;
                    w_tag_nxt     = r_tag + TAG_W'(1);
                    w_state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_bus_nxt   = IDLE_WORD;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tag     <= '0;
            r_cur_tag <= '0;
            r_bus     <= IDLE_WORD;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tag     <= w_tag_nxt;
            r_cur_tag <= w_cur_tag_nxt;
            r_bus     <= w_bus_nxt;
        end
    end

    l3_resp_fifo #(
        .DATA_W (c_ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_capture && !w_fifo_full),
        .push_data ({cache_in, r_cur_tag}),
        .pop       (resp_ready),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign resp_valid = !w_fifo_empty;
    assign resp_data  = w_head[c_ENTRY_W-1:TAG_W];
    assign resp_tag   = w_head[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_l3_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_l3_bus_master
// Brief    : Directed and randomized checks of l3_bus_master against a
//            timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l3_bus_master;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_data;
    logic [31:0]   bus_out;
    logic [31:0]   cache_in;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic [TW-1:0] resp_tag;
    logic          busy;

    always #5 clk = ~clk;

    l3_bus_master #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH),
        .TAG_W      (TW),
        .IDLE_WORD  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .bus_out    (bus_out),
        .cache_in   (cache_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a request accepted at edge k is captured at edge k+LAT+1.
    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
    } resp_t;

    resp_t         q[$];
    bit            inflight;
    int            edge_no;
    int            cap_edge;
    logic [31:0]   cur_data;
    logic [TW-1:0] cur_tag;
    logic [TW-1:0] next_tag;

    function automatic void model_reset();
        q.delete();
        inflight = 1'b0;
        next_tag = '0;
        cur_data = '0;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_ready;
        exp_ready = !inflight && (q.size() < DEPTH);
        check("req_ready",  {31'b0, req_ready},  {31'b0, exp_ready});
        check("busy",       {31'b0, busy},       {31'b0, inflight});
        check("bus_out",    bus_out,             inflight ? cur_data : 32'h0);
        check("resp_valid", {31'b0, resp_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            check("resp_data", resp_data,          q[0].data);
            check("resp_tag",  {28'b0, resp_tag},  {28'b0, q[0].tag});
        end
    endtask

    task automatic model_edge();
        bit rdy;
        edge_no++;
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = !inflight && (q.size() < DEPTH);
            if (resp_ready && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (inflight && edge_no == cap_edge) begin
                q.push_back('{cache_in, cur_tag});
                inflight = 1'b0;
            end else if (rdy && req_valid) begin
                inflight = 1'b1;
                cap_edge = edge_no + LAT + 1;
                cur_data = req_data;
                cur_tag  = next_tag;
                next_tag = next_tag + 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_data   = '0;
        cache_in   = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        edge_no = 0;
        model_reset();

        // Reset state
        apply_reset();
        tick();
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_bus_out", bus_out, 32'h0);

        // Single request; cache_in valid only in the cycle ending at E4
        req_valid = 1'b1;
        req_data  = 32'hDEAD_BEEF;
        tick();                          // E0
        req_valid = 1'b0;
        tick();                          // E1
        tick();                          // E2
        tick();                          // E3
        cache_in = 32'h1234_5678;
        tick();                          // E4
        cache_in = 32'h0;
        check("single_data", resp_data, 32'h1234_5678);
        check("single_tag", {28'b0, resp_tag}, 32'h0);
        check("single_bus_idle", bus_out, 32'h0);
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tick();

        // FIFO fill with no consumer, then release one entry
        apply_reset();
        req_valid = 1'b1;
        repeat (4 * (LAT + 2) + 3) begin
            req_data = $urandom;
            cache_in = $urandom;
            tick();
        end
        req_valid = 1'b0;
        check("full_ready", {31'b0, req_ready}, 32'h0);
        check("full_head_tag", {28'b0, resp_tag}, 32'h0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("release_ready", {31'b0, req_ready}, 32'h1);
        check("release_head_tag", {28'b0, resp_tag}, 32'h1);
        tick();

        // Tag wrap with a consumer that is always ready
        apply_reset();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        repeat (17 * (LAT + 2)) begin
            req_data = $urandom;
            cache_in = $urandom;
            tick();
        end
        req_valid = 1'b0;
        repeat (LAT + 3) tick();
        check("wrap_next_tag_model", {28'b0, next_tag}, 32'h1);

        // Reset asserted in the middle of a request
        apply_reset();
        req_valid = 1'b1;
        req_data  = 32'hCAFE_F00D;
        tick();                          // E0
        req_valid = 1'b0;
        tick();                          // E1
        tick();                          // E2
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_bus_out", bus_out, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
        tick();
        rst_n = 1'b1;
        req_valid = 1'b1;
        req_data  = 32'h0BAD_CAFE;
        tick();
        req_valid = 1'b0;
        repeat (LAT + 2) tick();
        check("midrst_tag_restart", {28'b0, resp_tag}, 32'h0);

        // req_valid held with changing data while busy
        apply_reset();
        req_valid = 1'b1;
        repeat (3 * (LAT + 2)) begin
            req_data = $urandom;
            cache_in = $urandom;
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (LAT + 6) tick();

        // Randomized traffic
        apply_reset();
        repeat (400) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            resp_ready = ($urandom_range(0, 2) == 0);
            req_data   = $urandom;
            cache_in   = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
